alu_exec_unit: RTL

Execute-stage ALU that consumes the 5-bit ALU operation code {func3[2:0], func7[6:5]} produced by the ALU control decoder, plus two XLEN operands. Add/sub/compare/logic complete in one cycle. Shifts run iteratively, one bit position per cycle, to keep area small. Valid/ready handshakes on both sides let the pipeline stall on shifts and on downstream backpressure.

---
 rtl/alu_exec_unit_pkg.sv | 38 +++
 rtl/alu_comb.sv | 38 +++
 rtl/alu_exec_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared ALU op encodings, FSM states and helpers
// Contents:
//   ALU_F3_*        3-bit func3 encodings, shared with the ALU control decoder
//   ALU_F7_ALT_BIT  position of the func7[5] alternate bit inside the 5-bit op
//   state_e         execute-unit FSM states
//   shift_e         shift flavour latched for the iterative shifter
//   is_shift()      true for func3 values handled by the iterative shifter
package alu_exec_unit_pkg;

   localparam logic [2:0] ALU_F3_ADD  = 3'b000;
   localparam logic [2:0] ALU_F3_SLL  = 3'b001;
   localparam logic [2:0] ALU_F3_SLT  = 3'b010;
   localparam logic [2:0] ALU_F3_SLTU = 3'b011;
   localparam logic [2:0] ALU_F3_XOR  = 3'b100;
   localparam logic [2:0] ALU_F3_SR   = 3'b101;
   localparam logic [2:0] ALU_F3_OR   = 3'b110;
   localparam logic [2:0] ALU_F3_AND  = 3'b111;

   // op = {func3[2:0], func7[6], func7[5]}; func7[6] is never used
   localparam int ALU_F7_ALT_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } shift_e;

   function automatic logic is_shift(input logic [2:0] f3);
      return (f3 == ALU_F3_SLL) || (f3 == ALU_F3_SR);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle ADD/SUB/SLT/SLTU/XOR/OR/AND datapath
// Ports:
//   func3_i   func3 field of the op
//   alt_i     func7[5]; selects SUB for func3 ADD, ignored otherwise
//   a_i, b_i  operands
//   result_o  result; zero for shift encodings (handled by the caller)
module alu_comb
   import alu_exec_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      func3_i,
   input  logic            alt_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] result_o
);

   logic lt_s;
   logic lt_u;

   assign lt_s = $signed(a_i) < $signed(b_i);
   assign lt_u = a_i < b_i;

   always_comb begin
      result_o = '0;
      case (func3_i)
         ALU_F3_ADD:  result_o = alt_i ? (a_i - b_i) : (a_i + b_i);
         ALU_F3_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
         ALU_F3_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
         ALU_F3_XOR:  result_o = a_i ^ b_i;
         ALU_F3_OR:   result_o = a_i | b_i;
         ALU_F3_AND:  result_o = a_i & b_i;
         default:     result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative one-bit-per-cycle shifter
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    request handshake; in_ready only in IDLE
//   in_op                {func3, func7[6:5]}
//   in_a, in_b           operands; shift amount is in_b[SHW-1:0]
//   out_valid/out_ready  result handshake; result held while stalled
//   out_result           registered result
//   out_zero             out_result == 0
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_zero
);

   state_e          state_q, state_d;
   shift_e          shop_q, shop_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [2:0]      func3;
   logic            alt;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] comb_res;
   logic [XLEN-1:0] shifted;
   logic            unused_op_bit;

   assign func3         = in_op[4:2];
   assign alt           = in_op[ALU_F7_ALT_BIT];
   assign shamt         = in_b[SHW-1:0];
   assign unused_op_bit = in_op[1];

   alu_comb #(.XLEN(XLEN)) u_alu_comb (
      .func3_i  (func3),
      .alt_i    (alt),
      .a_i      (in_a),
      .b_i      (in_b),
      .result_o (comb_res)
   );

   // result_q doubles as the shift register while in SHIFT
   always_comb begin
      shifted = result_q;
      case (shop_q)
         SH_SLL:  shifted = {result_q[XLEN-2:0], 1'b0};
         SH_SRL:  shifted = {1'b0, result_q[XLEN-1:1]};
         SH_SRA:  shifted = {result_q[XLEN-1], result_q[XLEN-1:1]};
         default: shifted = result_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      shop_d   = shop_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_shift(func3)) begin
                  result_d = in_a;
                  if (func3 == ALU_F3_SLL) begin
                     shop_d = SH_SLL;
                  end else begin
                     shop_d = alt ? SH_SRA : SH_SRL;
                  end
                  if (shamt == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     cnt_d   = shamt;
                     state_d = ST_SHIFT;
                  end
               end else begin
                  result_d = comb_res;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            result_d = shifted;
            cnt_d    = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
            // counter at 1 means this cycle performs the final shift
            if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shop_q   <= SH_SLL;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         shop_q   <= shop_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign out_result = result_q;
   assign out_zero   = (result_q == '0);

endmodule
